pifo_sorted_queue: RTL and testbench
====================================

Name: pifo_sorted_queue

Overview:
- Single-clock push-in/first-out (PIFO) priority queue that stores (port, priority, data-handle) entries in ascending priority order.
- Pop returns the smallest-priority entry for the requested port. Push-with-drop inserts an entry, then evicts the largest-priority entry.
- Sits in the slow clock domain of the descriptor scheduler, behind the CDC FIFOs. The data handle is a cell index into an external descriptor buffer.

Parameters:
NUMPIFO, 1024, entry capacity
BITPORT, 1, width of logical port tag
BITPRIO, 16, priority (rank) width, unsigned; smaller value = served first
BITDATA, 10, handle width (caller sets clog2(NUMPIFO))
PIFO_ID, 0, instance tag; simulation messages only, no functional effect

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
pop_0  in  1  pop request
oprt_0  in  BITPORT  port to pop from
ovld_0  out  1  popped-entry valid, one-cycle pulse
opri_0  out  BITPRIO  popped priority
odout_0  out  BITDATA  popped handle
push_1  in  1  push request, port 1
uprt_1  in  BITPORT  push port tag
upri_1  in  BITPRIO  push priority
udin_1  in  BITDATA  push handle
push_1_drop  in  1  qualifies push_1: evict after insert
push_2, uprt_2, upri_2, udin_2, push_2_drop  in  1/BITPORT/BITPRIO/BITDATA/1  second push port, same meaning
odrop_vld_0  out  1  evicted-entry valid, one-cycle pulse
odrop_pri_0  out  BITPRIO  evicted priority
odrop_dout_0  out  BITDATA  evicted handle

Behaviour:
- Storage is a sorted array of NUMPIFO slots plus an occupancy count.
  - Valid entries are packed at the head in non-decreasing priority.
  - Equal priorities keep insertion order (FIFO among equals).
- Reset: count=0; all slots invalid; ovld_0=0, odrop_vld_0=0, opri_0/odout_0/odrop_pri_0/odrop_dout_0=0.
- Outputs are registered. Data outputs hold their last value when the matching valid bit is low.
- No backpressure: every request is accepted in the cycle it is asserted.
- Pop, cycle N:
  - Selects the first (lowest-priority) valid entry whose port equals oprt_0, using array state at the start of cycle N.
  - If one exists: it is removed, the array is compacted, and ovld_0=1 with its priority/handle at N+1.
  - If none exists (empty, or no match): ovld_0=0 at N+1 and state is unchanged.
- Push, cycle N:
  - The entry is inserted after all entries with priority <= upri_1; count+1 at N+1.
  - Push ports: push_1 has precedence. push_2 is served only when push_1=0. When both are high, the push_2 request is ignored.
- Push with drop (pushX & pushX_drop):
  - Insert as above, then remove the tail entry of the sorted order. The tail is the largest priority; among ties, the most recently inserted. This may be the new entry itself.
  - odrop_vld_0=1 with the evicted priority/handle at N+1. Count is unchanged.
  - Port tags are ignored for eviction.
- Full (count==NUMPIFO) and push without drop: treated exactly as push with drop. No silent loss.
- Pop and push in the same cycle:
  - The pop is resolved first, on pre-push state; the new entry is not eligible for that pop.
  - Insertion (and eviction, if a drop applies) then operates on the post-pop array.
  - Count changes by +1-1 = 0, or -1 if a drop also applies.
  - ovld_0 and odrop_vld_0 may both pulse in the same cycle.
- Full plus pop plus plain push in the same cycle: the pop frees a slot, so no eviction occurs.
- Reset mid-operation clears all entries. No valid pulse is emitted in the cycle after reset.
- Comparators are unsigned BITPRIO wide, with no wrap-around handling.

Test Plan:
All scenarios use NUMPIFO=8, BITDATA=3, BITPORT=1.
- Reset: assert rst 2 cycles, then pop_0 port 0 -> ovld_0=0 next cycle; all outputs 0.
- Ordering: push (prio, data) (30,1),(10,2),(20,3),(10,4) on port 0; then 4 pops -> ovld_0 pulses return (10,2),(10,4),(20,3),(30,1); a 5th pop gives ovld_0=0.
- Drop: holding (5,0),(9,1),(7,2), push (8,3) with push_1_drop -> odrop_vld_0=1 with (9,1) next cycle. Push (50,4) with drop -> evicts (50,4) itself. Count stays 3.
- Full: push 8 entries with prios 1..8, then push (3,7) without drop -> odrop (8,·); subsequent pops return 1,2,3(old),3(new),4,5,6,7.
- Simultaneous: queue holds (4,0); same cycle pop port 0 + push (2,1) -> ovld_0 returns (4,0), not (2,1); next pop returns (2,1).
- Ports: push (1,0) on port 1 and (5,1) on port 0; pop with oprt_0=0 -> (5,1); push_1 and push_2 asserted together -> only push_1's entry is stored.

Source files
------------

// File: rtl/pifo_sorted_queue.sv
// pifo_sorted_queue
//   Push-in/first-out priority queue. Entries (port, priority, handle) are kept
//   packed at the head of a sorted array in non-decreasing priority order, with
//   FIFO order among equal priorities. Every request completes in one cycle.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   pop_0, oprt_0                     pop request and the port to pop from
//   ovld_0, opri_0, odout_0           registered pop result (valid is a pulse)
//   push_1, uprt_1, upri_1, udin_1    push request, port 1 (has precedence)
//   push_1_drop                       evict the tail entry after inserting
//   push_2, uprt_2, upri_2, udin_2,   second push port, served only when
//   push_2_drop                       push_1 is low
//   odrop_vld_0, odrop_pri_0,         registered eviction result (valid is a
//   odrop_dout_0                      pulse)
module pifo_sorted_queue #(
  parameter int unsigned NUMPIFO = 1024,
  parameter int unsigned BITPORT = 1,
  parameter int unsigned BITPRIO = 16,
  parameter int unsigned BITDATA = 10,
  parameter int unsigned PIFO_ID = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pop_0,
  input  logic [BITPORT-1:0] oprt_0,
  output logic               ovld_0,
  output logic [BITPRIO-1:0] opri_0,
  output logic [BITDATA-1:0] odout_0,
  input  logic               push_1,
  input  logic [BITPORT-1:0] uprt_1,
  input  logic [BITPRIO-1:0] upri_1,
  input  logic [BITDATA-1:0] udin_1,
  input  logic               push_1_drop,
  input  logic               push_2,
  input  logic [BITPORT-1:0] uprt_2,
  input  logic [BITPRIO-1:0] upri_2,
  input  logic [BITDATA-1:0] udin_2,
  input  logic               push_2_drop,
  output logic               odrop_vld_0,
  output logic [BITPRIO-1:0] odrop_pri_0,
  output logic [BITDATA-1:0] odrop_dout_0
);

  localparam int unsigned BITCNT = $clog2(NUMPIFO + 1);

  typedef struct packed {
    logic [BITPORT-1:0] prt;
    logic [BITPRIO-1:0] pri;
    logic [BITDATA-1:0] dat;
  } entry_t;

  // Instance tag only identifies the queue in simulation; it has no logic.
  logic pifo_id_unused;
  assign pifo_id_unused = (PIFO_ID != 0);

  entry_t           slot_q   [NUMPIFO];
  entry_t           slot_d   [NUMPIFO];
  logic [BITCNT-1:0] count_q, count_d;

  // Pop stage
  logic               pop_hit;
  int                 pop_idx;
  logic [BITPRIO-1:0] pop_pri;
  logic [BITDATA-1:0] pop_dat;
  entry_t             post_pop [NUMPIFO];
  int                 count1;

  // Push stage
  logic               psh;
  logic               psh_drop;
  entry_t             psh_entry;
  int                 ins_idx;
  logic               ins_found;
  entry_t             ins_arr  [NUMPIFO+1];
  logic               do_drop;
  logic [BITPRIO-1:0] evict_pri;
  logic [BITDATA-1:0] evict_dat;

  // Pop: first valid entry of the requested port, on start-of-cycle state.
  always_comb begin
    pop_hit = 1'b0;
    pop_idx = 0;
    for (int i = 0; i < NUMPIFO; i++) begin
      if (pop_0 && !pop_hit && (i < int'(count_q)) && (slot_q[i].prt == oprt_0)) begin
        pop_hit = 1'b1;
        pop_idx = i;
      end
    end
    pop_pri = slot_q[pop_idx].pri;
    pop_dat = slot_q[pop_idx].dat;
  end

  // Compact the array over the popped slot.
  always_comb begin
    for (int j = 0; j < NUMPIFO - 1; j++) begin
      post_pop[j] = (pop_hit && (j >= pop_idx)) ? slot_q[j+1] : slot_q[j];
    end
    post_pop[NUMPIFO-1] = slot_q[NUMPIFO-1];
    count1 = int'(count_q) - (pop_hit ? 1 : 0);
  end

  // Push port arbitration: push_1 wins, a concurrent push_2 is discarded.
  always_comb begin
    psh       = 1'b0;
    psh_drop  = 1'b0;
    psh_entry = '0;
    if (push_1) begin
      psh       = 1'b1;
      psh_drop  = push_1_drop;
      psh_entry = '{prt: uprt_1, pri: upri_1, dat: udin_1};
    end else if (push_2) begin
      psh       = 1'b1;
      psh_drop  = push_2_drop;
      psh_entry = '{prt: uprt_2, pri: upri_2, dat: udin_2};
    end
  end

  // Insert after every entry with priority <= new priority, on post-pop state.
  always_comb begin
    ins_idx   = count1;
    ins_found = 1'b0;
    for (int j = 0; j < NUMPIFO; j++) begin
      if (!ins_found && (j < count1) && (post_pop[j].pri > psh_entry.pri)) begin
        ins_found = 1'b1;
        ins_idx   = j;
      end
    end
    // One extra slot so a full array can hold the new entry before eviction.
    ins_arr[0] = (ins_idx == 0) ? psh_entry : post_pop[0];
    for (int j = 1; j < NUMPIFO; j++) begin
      if (j < ins_idx) begin
        ins_arr[j] = post_pop[j];
      end else if (j == ins_idx) begin
        ins_arr[j] = psh_entry;
      end else begin
        ins_arr[j] = post_pop[j-1];
      end
    end
    ins_arr[NUMPIFO] = (ins_idx == NUMPIFO) ? psh_entry : post_pop[NUMPIFO-1];
  end

  // Eviction: the tail of the post-insert order sits at index count1. A push
  // into a still-full array (no pop this cycle) always evicts.
  always_comb begin
    do_drop   = psh && (psh_drop || (count1 == int'(NUMPIFO)));
    evict_pri = ins_arr[count1].pri;
    evict_dat = ins_arr[count1].dat;
    if (psh) begin
      for (int j = 0; j < NUMPIFO; j++) begin
        slot_d[j] = ins_arr[j];
      end
      count_d = do_drop ? BITCNT'(count1) : BITCNT'(count1 + 1);
    end else begin
      for (int j = 0; j < NUMPIFO; j++) begin
        slot_d[j] = post_pop[j];
      end
      count_d = BITCNT'(count1);
    end
  end

  // Slot contents beyond count are don't-care, so they need no reset.
  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      ovld_0       <= 1'b0;
      opri_0       <= '0;
      odout_0      <= '0;
      odrop_vld_0  <= 1'b0;
      odrop_pri_0  <= '0;
      odrop_dout_0 <= '0;
    end else begin
      count_q     <= count_d;
      ovld_0      <= pop_hit;
      odrop_vld_0 <= do_drop;
      if (pop_hit) begin
        opri_0  <= pop_pri;
        odout_0 <= pop_dat;
      end
      if (do_drop) begin
        odrop_pri_0  <= evict_pri;
        odrop_dout_0 <= evict_dat;
      end
    end
  end

endmodule

// File: tb/tb_pifo_sorted_queue.sv
// Directed bench for pifo_sorted_queue with NUMPIFO=8, BITDATA=3, BITPORT=1.
module tb_pifo_sorted_queue;

  localparam int unsigned NUMPIFO = 8;
  localparam int unsigned BITPORT = 1;
  localparam int unsigned BITPRIO = 16;
  localparam int unsigned BITDATA = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               pop_0;
  logic [BITPORT-1:0] oprt_0;
  logic               ovld_0;
  logic [BITPRIO-1:0] opri_0;
  logic [BITDATA-1:0] odout_0;
  logic               push_1, push_1_drop;
  logic [BITPORT-1:0] uprt_1;
  logic [BITPRIO-1:0] upri_1;
  logic [BITDATA-1:0] udin_1;
  logic               push_2, push_2_drop;
  logic [BITPORT-1:0] uprt_2;
  logic [BITPRIO-1:0] upri_2;
  logic [BITDATA-1:0] udin_2;
  logic               odrop_vld_0;
  logic [BITPRIO-1:0] odrop_pri_0;
  logic [BITDATA-1:0] odrop_dout_0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pifo_sorted_queue #(
    .NUMPIFO(NUMPIFO),
    .BITPORT(BITPORT),
    .BITPRIO(BITPRIO),
    .BITDATA(BITDATA),
    .PIFO_ID(0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pop_0        (pop_0),
    .oprt_0       (oprt_0),
    .ovld_0       (ovld_0),
    .opri_0       (opri_0),
    .odout_0      (odout_0),
    .push_1       (push_1),
    .uprt_1       (uprt_1),
    .upri_1       (upri_1),
    .udin_1       (udin_1),
    .push_1_drop  (push_1_drop),
    .push_2       (push_2),
    .uprt_2       (uprt_2),
    .upri_2       (upri_2),
    .udin_2       (udin_2),
    .push_2_drop  (push_2_drop),
    .odrop_vld_0  (odrop_vld_0),
    .odrop_pri_0  (odrop_pri_0),
    .odrop_dout_0 (odrop_dout_0)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    rst = 1'b0; pop_0 = 1'b0; oprt_0 = '0;
    push_1 = 1'b0; push_1_drop = 1'b0; uprt_1 = '0; upri_1 = '0; udin_1 = '0;
    push_2 = 1'b0; push_2_drop = 1'b0; uprt_2 = '0; upri_2 = '0; udin_2 = '0;
  endtask

  // Apply the currently driven inputs for one cycle; outputs are then sampled
  // 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic set_push1(input int pri, input int dat, input int prt, input bit drop);
    push_1 = 1'b1; upri_1 = BITPRIO'(pri); udin_1 = BITDATA'(dat);
    uprt_1 = BITPORT'(prt); push_1_drop = drop;
  endtask

  task automatic set_push2(input int pri, input int dat, input int prt, input bit drop);
    push_2 = 1'b1; upri_2 = BITPRIO'(pri); udin_2 = BITDATA'(dat);
    uprt_2 = BITPORT'(prt); push_2_drop = drop;
  endtask

  task automatic push_nodrop(input string tag, input int pri, input int dat, input int prt);
    set_push1(pri, dat, prt, 1'b0);
    tick();
    check_eq({tag, "_nodrop"}, int'(odrop_vld_0), 0);
  endtask

  task automatic expect_pop(input string tag, input int vld, input int pri, input int dat);
    check_eq({tag, "_vld"}, int'(ovld_0), vld);
    if (vld != 0) begin
      check_eq({tag, "_pri"}, int'(opri_0), pri);
      check_eq({tag, "_dat"}, int'(odout_0), dat);
    end
  endtask

  task automatic pop_chk(input string tag, input int prt, input int vld, input int pri,
                         input int dat);
    pop_0 = 1'b1; oprt_0 = BITPORT'(prt);
    tick();
    expect_pop(tag, vld, pri, dat);
  endtask

  task automatic expect_drop(input string tag, input int pri, input int dat);
    check_eq({tag, "_dvld"}, int'(odrop_vld_0), 1);
    check_eq({tag, "_dpri"}, int'(odrop_pri_0), pri);
    check_eq({tag, "_ddat"}, int'(odrop_dout_0), dat);
  endtask

  initial begin
    clear_inputs();
    // Reset
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    pop_0 = 1'b1;
    tick();
    check_eq("rst_ovld", int'(ovld_0), 0);
    check_eq("rst_opri", int'(opri_0), 0);
    check_eq("rst_odout", int'(odout_0), 0);
    check_eq("rst_dvld", int'(odrop_vld_0), 0);
    check_eq("rst_dpri", int'(odrop_pri_0), 0);
    check_eq("rst_ddat", int'(odrop_dout_0), 0);

    // Ordering, FIFO among equal priorities, hold on empty pop
    push_nodrop("ord_p0", 30, 1, 0);
    push_nodrop("ord_p1", 10, 2, 0);
    push_nodrop("ord_p2", 20, 3, 0);
    push_nodrop("ord_p3", 10, 4, 0);
    pop_chk("ord_q0", 0, 1, 10, 2);
    pop_chk("ord_q1", 0, 1, 10, 4);
    pop_chk("ord_q2", 0, 1, 20, 3);
    pop_chk("ord_q3", 0, 1, 30, 1);
    pop_chk("ord_q4", 0, 0, 0, 0);
    check_eq("ord_hold_pri", int'(opri_0), 30);
    check_eq("ord_hold_dat", int'(odout_0), 1);

    // Push with drop
    push_nodrop("drp_p0", 5, 0, 0);
    push_nodrop("drp_p1", 9, 1, 0);
    push_nodrop("drp_p2", 7, 2, 0);
    set_push1(8, 3, 0, 1'b1);
    tick();
    expect_drop("drp_a", 9, 1);
    set_push1(50, 4, 0, 1'b1);
    tick();
    expect_drop("drp_b", 50, 4);
    pop_chk("drp_q0", 0, 1, 5, 0);
    pop_chk("drp_q1", 0, 1, 7, 2);
    pop_chk("drp_q2", 0, 1, 8, 3);
    pop_chk("drp_q3", 0, 0, 0, 0);

    // Full queue: plain push behaves as push with drop
    for (int i = 1; i <= 8; i++) push_nodrop("full_fill", i, i - 1, 0);
    set_push1(3, 7, 0, 1'b0);
    tick();
    expect_drop("full_ev", 8, 7);
    pop_chk("full_q0", 0, 1, 1, 0);
    pop_chk("full_q1", 0, 1, 2, 1);
    pop_chk("full_q2", 0, 1, 3, 2);
    pop_chk("full_q3", 0, 1, 3, 7);
    pop_chk("full_q4", 0, 1, 4, 3);
    pop_chk("full_q5", 0, 1, 5, 4);
    pop_chk("full_q6", 0, 1, 6, 5);
    pop_chk("full_q7", 0, 1, 7, 6);
    pop_chk("full_q8", 0, 0, 0, 0);

    // Simultaneous pop and push: the new entry is not eligible for the pop
    push_nodrop("sim_p0", 4, 0, 0);
    pop_0 = 1'b1; oprt_0 = 1'b0;
    set_push1(2, 1, 0, 1'b0);
    tick();
    expect_pop("sim_a", 1, 4, 0);
    check_eq("sim_a_dvld", int'(odrop_vld_0), 0);
    pop_chk("sim_b", 0, 1, 2, 1);
    pop_chk("sim_c", 0, 0, 0, 0);

    // Port matching and push port precedence
    push_nodrop("prt_p0", 1, 0, 1);
    push_nodrop("prt_p1", 5, 1, 0);
    pop_chk("prt_q0", 0, 1, 5, 1);
    pop_chk("prt_q1", 0, 0, 0, 0);
    pop_chk("prt_q2", 1, 1, 1, 0);
    set_push1(3, 2, 0, 1'b0);
    set_push2(4, 5, 0, 1'b0);
    tick();
    pop_chk("prt_q3", 0, 1, 3, 2);
    pop_chk("prt_q4", 0, 0, 0, 0);

    // Full plus pop plus plain push: the pop frees a slot, no eviction.
    // Filled through push_2 alone.
    for (int i = 0; i < 8; i++) begin
      set_push2(10 + i, i, 0, 1'b0);
      tick();
      check_eq("fp_fill_nodrop", int'(odrop_vld_0), 0);
    end
    pop_0 = 1'b1; oprt_0 = 1'b0;
    set_push1(12, 7, 0, 1'b0);
    tick();
    expect_pop("fp_a", 1, 10, 0);
    check_eq("fp_a_dvld", int'(odrop_vld_0), 0);
    // Full again: a plain push with a larger priority evicts itself
    set_push2(20, 1, 0, 1'b0);
    tick();
    expect_drop("fp_b", 20, 1);
    pop_chk("fp_q0", 0, 1, 11, 1);
    pop_chk("fp_q1", 0, 1, 12, 2);
    pop_chk("fp_q2", 0, 1, 12, 7);

    // Reset mid-operation clears the queue and suppresses pulses
    pop_0 = 1'b1; oprt_0 = 1'b0;
    rst = 1'b1;
    tick();
    check_eq("mrst_ovld", int'(ovld_0), 0);
    check_eq("mrst_opri", int'(opri_0), 0);
    pop_chk("mrst_q0", 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
